brdg_int_collector: RTL and testbench

BRDG_INT_COLLECTOR -- requirements
Module: brdg_int_collector

---
 rtl/brdg_int_pkg.sv | 15 +
 rtl/brdg_rr_pick.sv | 33 +++
 rtl/brdg_int_collector.sv | 133 +++++++++++++
 tb/tb_brdg_int_collector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/brdg_int_pkg.sv
// Shared definitions for the interrupt collector: state encodings and defaults.
// Imported by the collector top level.
package brdg_int_pkg;

    localparam int BRDG_NUM_SRC_DEF = 4;
    localparam int BRDG_OBJ_W       = 64;

    // One-hot so each state is a single flop decode.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'b001,
        ST_ISSUE     = 3'b010,
        ST_WAIT_DROP = 3'b100
    } brdg_state_t;

endpackage

// File: rtl/brdg_rr_pick.sv
// Wrapping priority picker: lowest requesting index at or above i_ptr,
// wrapping past NUM_SRC-1 back to 0. Purely combinational.
module brdg_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [PTR_W-1:0]   o_idx
);

    localparam int PW1 = PTR_W + 1;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        logic [PW1-1:0] w_pos;
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_ptr} + PW1'(k);
            if (w_pos >= PW1'(NUM_SRC)) begin
                w_pos = w_pos - PW1'(NUM_SRC);
            end
            if (i_req[w_pos[PTR_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/brdg_int_collector.sv
// Collects per-source interrupt objects and presents them one at a time,
// round-robin, over a level request / level acknowledge bridge handshake.
module brdg_int_collector
    import brdg_int_pkg::*;
#(
    parameter int NUM_SRC = BRDG_NUM_SRC_DEF,
    parameter int PTR_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC*64-1:0]     src_obj,
    input  logic [NUM_SRC-1:0]        src_enable,
    output logic [NUM_SRC-1:0]        src_done,
    output logic [NUM_SRC-1:0]        src_ovf,
    input  logic [NUM_SRC-1:0]        ovf_clr,
    output logic                      interrupt,
    output logic [BRDG_OBJ_W-1:0]     interrupt_src,
    input  logic                      interrupt_ack,
    output logic                      busy
);

    brdg_state_t               r_state;
    logic                      r_interrupt;
    logic [BRDG_OBJ_W-1:0]     r_int_src;
    logic [PTR_W-1:0]          r_grant;
    logic [PTR_W-1:0]          r_rr_ptr;
    logic [NUM_SRC-1:0]        r_done;

    logic [NUM_SRC-1:0]        w_pending;
    logic [NUM_SRC-1:0]        w_ovf;
    logic [BRDG_OBJ_W-1:0]     w_obj [NUM_SRC];
    logic                      w_exit;
    logic                      w_pick_valid;
    logic [PTR_W-1:0]          w_pick_idx;

    // Completion of the current grant: bridge has released ack in WAIT_DROP.
    assign w_exit = (r_state == ST_WAIT_DROP) && !interrupt_ack;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic                  r_pending;
        logic                  r_ovf;
        logic [BRDG_OBJ_W-1:0] r_obj;
        logic                  w_clr;
        logic                  w_set;

        assign w_clr = w_exit && (r_grant == PTR_W'(gi));
        // A new request lands when the slot is empty or is being freed this cycle.
        assign w_set = src_req[gi] && (!r_pending || w_clr);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pending <= 1'b0;
                r_ovf     <= 1'b0;
                r_obj     <= '0;
            end else begin
                if (w_set) begin
                    r_pending <= 1'b1;
                    r_obj     <= src_obj[64*gi +: 64];
                end else if (w_clr) begin
                    r_pending <= 1'b0;
                end
                if (src_req[gi] && r_pending && !w_clr) begin
                    r_ovf <= 1'b1;
                end else if (ovf_clr[gi]) begin
                    r_ovf <= 1'b0;
                end
            end
        end

        assign w_pending[gi] = r_pending;
        assign w_ovf[gi]     = r_ovf;
        assign w_obj[gi]     = r_obj;
    end

    brdg_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req   (w_pending & src_enable),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_interrupt <= 1'b0;
            r_int_src   <= '0;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_done      <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    // Wait for the bridge to be quiescent before starting a new grant.
                    if (w_pick_valid && !interrupt_ack) begin
                        r_grant     <= w_pick_idx;
                        r_int_src   <= w_obj[w_pick_idx];
                        r_interrupt <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (interrupt_ack) begin
                        r_interrupt <= 1'b0;
                        r_state     <= ST_WAIT_DROP;
                    end
                end
                ST_WAIT_DROP: begin
                    if (!interrupt_ack) begin
                        r_done   <= NUM_SRC'(1) << r_grant;
                        r_rr_ptr <= (r_grant == PTR_W'(NUM_SRC - 1)) ? '0 : r_grant + 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_interrupt <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign interrupt     = r_interrupt;
    assign interrupt_src = r_int_src;
    assign busy          = (r_state != ST_IDLE);
    assign src_done      = r_done;
    assign src_ovf       = w_ovf;

endmodule

// File: tb/tb_brdg_int_collector.sv
// Directed bench for brdg_int_collector: single source, round-robin order,
// overflow, set/clear collision, masking and reset during ISSUE.
module tb_brdg_int_collector;

    localparam int NUM_SRC = 4;
    localparam int PTR_W   = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_SRC-1:0]     src_req;
    logic [NUM_SRC*64-1:0]  src_obj;
    logic [NUM_SRC-1:0]     src_enable;
    logic [NUM_SRC-1:0]     src_done;
    logic [NUM_SRC-1:0]     src_ovf;
    logic [NUM_SRC-1:0]     ovf_clr;
    logic                   interrupt;
    logic [63:0]            interrupt_src;
    logic                   interrupt_ack;
    logic                   busy;

    int n_total = 0;
    int n_bad   = 0;

    brdg_int_collector #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_req       (src_req),
        .src_obj       (src_obj),
        .src_enable    (src_enable),
        .src_done      (src_done),
        .src_ovf       (src_ovf),
        .ovf_clr       (ovf_clr),
        .interrupt     (interrupt),
        .interrupt_src (interrupt_src),
        .interrupt_ack (interrupt_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_obj(input int idx, input logic [63:0] val);
        src_obj[64*idx +: 64] = val;
    endtask

    task automatic pulse_req(input logic [NUM_SRC-1:0] mask);
        src_req = mask;
        tick();
        src_req = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Wait for interrupt, check object, acknowledge once and check completion.
    task automatic serve(input string tag, input logic [63:0] exp_src, input int exp_idx);
        for (int k = 0; k < 20 && !interrupt; k++) tick();
        chk({tag, "_irq"}, interrupt, 1);
        chk({tag, "_src"}, interrupt_src, exp_src);
        interrupt_ack = 1'b1;
        tick();
        chk({tag, "_drop"}, interrupt, 0);
        interrupt_ack = 1'b0;
        tick();
        chk({tag, "_done"}, src_done, 64'(1 << exp_idx));
        chk({tag, "_hold"}, interrupt_src, exp_src);
    endtask

    initial begin
        rst           = 1'b1;
        src_req       = '0;
        src_obj       = '0;
        src_enable    = '1;
        ovf_clr       = '0;
        interrupt_ack = 1'b0;
        tick();
        tick();
        chk("rst_irq",  interrupt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_src",  interrupt_src, 0);
        chk("rst_done", src_done, 0);
        chk("rst_ovf",  src_ovf, 0);
        rst = 1'b0;
        tick();

        // Single source: request in cycle 0, interrupt seen in cycle 2.
        set_obj(0, 64'hA5);
        pulse_req(4'b0001);
        chk("single_c1_irq", interrupt, 0);
        tick();
        chk("single_c2_irq", interrupt, 1);
        chk("single_c2_src", interrupt_src, 64'hA5);
        chk("single_busy",   busy, 1);
        interrupt_ack = 1'b1;
        tick();
        chk("single_drop", interrupt, 0);
        tick();
        tick();
        interrupt_ack = 1'b0;
        chk("single_nodone_early", src_done, 0);
        tick();
        chk("single_done", src_done, 64'h1);
        chk("single_idle", busy, 0);
        tick();
        chk("single_done_once", src_done, 0);

        // Round-robin from rr_ptr=0 with all four sources pending.
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) set_obj(i, 64'h10 + 64'(i));
        pulse_req(4'b1111);
        serve("rr_a0", 64'h10, 0);
        serve("rr_a1", 64'h11, 1);
        serve("rr_a2", 64'h12, 2);
        serve("rr_a3", 64'h13, 3);
        set_obj(0, 64'h50);
        pulse_req(4'b0001);
        serve("rr_b0", 64'h50, 0);
        set_obj(0, 64'h60);
        set_obj(1, 64'h61);
        pulse_req(4'b0011);
        serve("rr_b1_first",  64'h61, 1);
        serve("rr_b0_second", 64'h60, 0);

        // Overflow: second request on a busy slot is dropped and flagged.
        set_obj(2, 64'h21);
        pulse_req(4'b0100);
        set_obj(2, 64'h22);
        pulse_req(4'b0100);
        chk("ovf_set", src_ovf, 64'h4);
        serve("ovf_first", 64'h21, 2);
        for (int k = 0; k < 6; k++) tick();
        chk("ovf_no_second", interrupt, 0);
        chk("ovf_sticky", src_ovf, 64'h4);
        ovf_clr = 4'b0100;
        tick();
        ovf_clr = '0;
        chk("ovf_clr", src_ovf, 0);

        // Set/clear collision on the WAIT_DROP exit cycle of source 1.
        set_obj(1, 64'h31);
        pulse_req(4'b0010);
        for (int k = 0; k < 20 && !interrupt; k++) tick();
        chk("coll_src1", interrupt_src, 64'h31);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        set_obj(1, 64'h32);
        src_req = 4'b0010;
        tick();
        src_req = '0;
        chk("coll_done", src_done, 64'h2);
        chk("coll_ovf",  src_ovf, 0);
        serve("coll_second", 64'h32, 1);
        chk("coll_ovf_after", src_ovf, 0);

        // Masking: a disabled source stays pending without raising interrupt.
        src_enable = 4'b0111;
        set_obj(3, 64'h40);
        pulse_req(4'b1000);
        for (int k = 0; k < 5; k++) tick();
        chk("mask_no_irq",  interrupt, 0);
        chk("mask_no_busy", busy, 0);
        src_enable = 4'b1111;
        tick();
        tick();
        chk("mask_irq", interrupt, 1);
        serve("mask_serve", 64'h40, 3);

        // Reset in ISSUE: interrupt drops at once, no completion, nothing pending.
        set_obj(0, 64'h55);
        set_obj(2, 64'h57);
        pulse_req(4'b0101);
        for (int k = 0; k < 20 && !interrupt; k++) tick();
        chk("rsti_irq_before", interrupt, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rsti_irq_now",  interrupt, 0);
        chk("rsti_busy_now", busy, 0);
        tick();
        chk("rsti_done_in_rst", src_done, 0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (src_done != 0 || interrupt) break;
        end
        chk("rsti_no_done",  src_done, 0);
        chk("rsti_no_irq",   interrupt, 0);
        chk("rsti_src_zero", interrupt_src, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
